// File: rtl/cnn_frame_scheduler.sv
// rtl/cnn_frame_scheduler.sv - ping-pong frame buffer feeding the CNN core and returning class results
module cnn_frame_scheduler #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 784,
    parameter int CLASS_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data,
    output logic               core_start,
    output logic [DATA_W-1:0]  core_din,
    input  logic               core_din_ready,
    input  logic               core_conv1_done,
    input  logic               core_done,
    input  logic [CLASS_W-1:0] core_classes,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [CLASS_W-1:0] r_classes,
    output logic [7:0]         r_frame_id,
    output logic               busy,
    output logic               err
);
    localparam int AW = $clog2(FRAME_LEN + 1);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] LEN  = AW'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, FEED, WAIT_DONE, RESULT} state_t;
    state_t state, state_n;

    logic [DATA_W-1:0] bank0 [FRAME_LEN];
    logic [DATA_W-1:0] bank1 [FRAME_LEN];
    logic [1:0]        full, set_mask, clr_mask;
    logic              wb, rb, rdy_en, conv1_seen;
    logic [AW-1:0]     wcnt, rptr;
    logic [7:0]        fid;
    logic              wr_en, wr_last, rd_en, excess, feed_end, early_done;

    // rdy_en keeps s_ready low through reset and releases it one edge later
    assign s_ready    = rdy_en & ~full[wb];
    assign wr_en      = s_valid & s_ready;
    assign wr_last    = wr_en && (wcnt == LAST);
    assign rd_en      = (state == FEED) && core_din_ready && (rptr < LEN);
    assign excess     = ((state == FEED) || (state == WAIT_DONE)) && core_din_ready && (rptr == LEN);
    assign early_done = (state == FEED) && core_done;
    assign feed_end   = (state == FEED) && (rptr == LEN) && !core_done;
    assign set_mask   = wr_last ? (2'b01 << wb) : 2'b00;
    assign clr_mask   = (early_done || feed_end) ? (2'b01 << rb) : 2'b00;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wb) bank1[wcnt] <= s_data;
            else    bank0[wcnt] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 2'b00;
            wb     <= 1'b0;
            wcnt   <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            full   <= (full | set_mask) & ~clr_mask;
            if (wr_en) begin
                if (wr_last) begin
                    wcnt <= '0;
                    wb   <= ~wb;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (full[rb]) state_n = FEED;
            FEED: begin
                if (core_done)        state_n = RESULT;
                else if (rptr == LEN) state_n = WAIT_DONE;
            end
            WAIT_DONE: if (core_done) state_n = RESULT;
            RESULT:    if (r_ready)   state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        core_start = 1'b0;
        r_valid    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE:    busy       = 1'b0;
            FEED:    core_start = !conv1_seen;
            RESULT:  r_valid    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb         <= 1'b0;
            rptr       <= '0;
            fid        <= 8'd0;
            conv1_seen <= 1'b0;
            core_din   <= '0;
            r_classes  <= '0;
            r_frame_id <= 8'd0;
            err        <= 1'b0;
        end else begin
            if (state == IDLE && full[rb]) begin
                rptr       <= '0;
                conv1_seen <= 1'b0;
            end
            if (state == FEED && core_conv1_done) conv1_seen <= 1'b1;
            if (rd_en) begin
                core_din <= rb ? bank1[rptr] : bank0[rptr];
                rptr     <= rptr + 1'b1;
            end else if (excess) begin
                core_din <= '0;
                err      <= 1'b1;
            end
            if (early_done || feed_end) rb <= ~rb;
            // a done that arrives mid-feed still reports its result, but flags the protocol error
            if (core_done) begin
                if (state == FEED || state == WAIT_DONE) begin
                    r_classes  <= core_classes;
                    r_frame_id <= fid;
                    fid        <= fid + 8'd1;
                end
                if (state != WAIT_DONE) err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// tb/tb_cnn_frame_scheduler.sv - scoreboard bench for cnn_frame_scheduler
module tb_cnn_frame_scheduler;
    localparam int L = 784;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, core_start, core_din_ready, core_conv1_done, core_done;
    logic        r_valid, r_ready, busy, err;
    logic [31:0] s_data, core_din;
    logic [9:0]  core_classes, r_classes;
    logic [7:0]  r_frame_id;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_din[$];
    logic [17:0] exp_res[$];
    logic [7:0]  exp_fid = 8'd0;

    cnn_frame_scheduler #(.DATA_W(32), .FRAME_LEN(L), .CLASS_W(10)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_start(core_start), .core_din(core_din), .core_din_ready(core_din_ready),
        .core_conv1_done(core_conv1_done), .core_done(core_done), .core_classes(core_classes),
        .r_valid(r_valid), .r_ready(r_ready), .r_classes(r_classes), .r_frame_id(r_frame_id),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/empty expected event", name);
    endtask

    task automatic push_frame(input logic [31:0] base, input int n);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 30000) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = base + i;
            if (s_ready) begin
                exp_din.push_back(base + i);
                i++;
            end
            guard++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        if (i < n) fail_now("push_timeout");
    endtask

    // mode: 0 continuous, 1 bursty, 2 early done at target, 3 one excess word, 4 stop at target
    task automatic run_core(input int mode, input int target, input logic [9:0] cls);
        int   got = 0;
        int   cyc = 0;
        int   guard = 0;
        logic pend = 1'b0;
        logic c1 = 1'b0;
        logic c1chk = 1'b0;
        @(negedge clk);
        while (!core_start && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (!core_start) begin
            fail_now("core_start_timeout");
            return;
        end
        guard = 0;
        while (got < target && guard < 20000) begin
            core_conv1_done = 1'b0;
            if (pend) begin
                if (exp_din.size() == 0) fail_now("din_queue");
                else check("core_din", core_din, exp_din.pop_front());
                got++;
            end
            if (c1chk) begin
                check("core_start_after_conv1", {31'd0, core_start}, 32'd0);
                c1chk = 1'b0;
            end
            if (!c1 && got >= 20 && got < target) begin
                check("core_start_before_conv1", {31'd0, core_start}, 32'd1);
                core_conv1_done = 1'b1;
                c1 = 1'b1;
                c1chk = 1'b1;
            end
            core_din_ready = (got < target) && (mode != 1 || (cyc / 3) % 2 == 0);
            pend = core_din_ready;
            cyc++;
            guard++;
            if (got < target) @(negedge clk);
        end
        if (got < target) fail_now("feed_timeout");
        if (mode == 4) return;
        if (mode == 2) begin
            core_done = 1'b1;
            core_classes = cls;
            exp_res.push_back({cls, exp_fid});
            exp_fid++;
            @(negedge clk);
            core_done = 1'b0;
            check("err_early_done", {31'd0, err}, 32'd1);
            for (int k = 0; k < L - target; k++) void'(exp_din.pop_front());
            return;
        end
        if (mode == 3) begin
            core_din_ready = 1'b1;
            @(negedge clk);
            core_din_ready = 1'b0;
            check("excess_core_din", core_din, 32'd0);
            check("err_excess", {31'd0, err}, 32'd1);
        end
        repeat (8) @(negedge clk);
        core_done = 1'b1;
        core_classes = cls;
        exp_res.push_back({cls, exp_fid});
        exp_fid++;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    task automatic wait_results();
        int guard = 0;
        while ((exp_res.size() != 0 || r_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (exp_res.size() != 0) fail_now("result_timeout");
    endtask

    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (r_valid && r_ready) begin
                if (exp_res.size() == 0) fail_now("unexpected_result");
                else begin
                    e = exp_res.pop_front();
                    check("r_classes", {22'd0, r_classes}, {22'd0, e[17:8]});
                    check("r_frame_id", {24'd0, r_frame_id}, {24'd0, e[7:0]});
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_core_start", {31'd0, core_start}, 32'd0);
        check("rst_core_din", core_din, 32'd0);
        check("rst_r_valid", {31'd0, r_valid}, 32'd0);
        check("rst_r_classes", {22'd0, r_classes}, 32'd0);
        check("rst_r_frame_id", {24'd0, r_frame_id}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; core_din_ready = 1'b0;
        core_conv1_done = 1'b0; core_done = 1'b0; core_classes = '0; r_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_reset", {31'd0, s_ready}, 32'd1);

        fork push_frame(32'd0, L); run_core(0, L, 10'h004); join
        wait_results();

        fork
            begin push_frame(32'd1000, L); push_frame(32'd2000, L); push_frame(32'd3000, L); end
            begin run_core(0, L, 10'h011); run_core(0, L, 10'h022); run_core(0, L, 10'h033); end
        join
        wait_results();

        r_ready = 1'b0;
        fork
            begin push_frame(32'd5000, L); push_frame(32'd6000, L); end
            run_core(0, L, 10'h155);
        join
        repeat (50) @(negedge clk);
        check("bp_r_valid_held", {31'd0, r_valid}, 32'd1);
        check("bp_r_classes", {22'd0, r_classes}, 32'h155);
        check("bp_next_feed_waits", {31'd0, core_start}, 32'd0);
        r_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_one_cycle", {31'd0, r_valid}, 32'd0);
        run_core(0, L, 10'h2aa);
        wait_results();

        fork push_frame(32'd7000, L); run_core(1, L, 10'h007); join
        wait_results();
        check("bursty_err_clear", {31'd0, err}, 32'd0);

        fork push_frame(32'd8000, L); run_core(3, L, 10'h0f0); join
        wait_results();

        push_frame(32'd9000, L);
        fork push_frame(32'd9500, 200); run_core(4, 300, 10'h000); join
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        exp_din.delete();
        exp_res.delete();
        exp_fid = 8'd0;
        repeat (5) @(negedge clk);
        check("buffered_frames_dropped", {31'd0, busy}, 32'd0);

        fork push_frame(32'd10000, L); run_core(0, L, 10'h0aa); join
        wait_results();

        fork push_frame(32'd11000, L); run_core(2, 400, 10'h3c3); join
        wait_results();

        fork push_frame(32'd12000, L); run_core(0, L, 10'h012); join
        wait_results();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
